// File: rtl/j1_uart.sv
// j1_uart: memory-mapped 8N1 UART for the J1 CPU.
// TX/RX FIFOs, programmable divisor, loopback and level irq.

module j1_uart_fifo #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       accept
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_pop;
  logic        do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign accept  = do_push;
  assign dout    = empty ? 8'h00 : mem[rptr[AW-1:0]];

  // pointers wrap naturally over AW+1 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // storage array, contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

module j1_uart #(
  parameter logic [15:0] BASE_ADDR = 16'h4000,
  parameter logic [15:0] BAUD_DIV  = 16'd434,
  parameter int          FIFO_AW   = 4
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        io_rd_i,
  input  logic        io_wr_i,
  input  logic [15:0] io_addr_i,
  input  logic [15:0] io_data_i,
  output logic [15:0] io_data_o,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_t;

  logic        hit;
  logic [1:0]  sel;
  logic        wr_data;
  logic        wr_stat;
  logic        wr_div;
  logic        wr_ctrl;
  logic        rd_data;
  logic        unused_ok;

  logic [15:0] div_q;
  logic [15:0] div_eff;
  logic [1:0]  ctrl_q;
  logic        rx_ovf_q;
  logic        rx_ferr_q;
  logic        tx_ovf_q;

  logic [7:0]  tx_head;
  logic        tx_fempty;
  logic        tx_full;
  logic        tx_acc;
  logic        tx_pop;
  logic        tx_empty;

  logic [7:0]  rx_head;
  logic        rx_fempty;
  logic        rx_full;
  logic        rx_acc;
  logic        rx_push;
  logic        rx_valid;
  logic        rx_ferr_set;
  logic        rx_ovf_set;
  logic        tx_ovf_set;

  ser_state_t  tx_state;
  ser_state_t  tx_state_d;
  logic [15:0] tx_cnt;
  logic [15:0] tx_cnt_d;
  logic [2:0]  tx_bit;
  logic [2:0]  tx_bit_d;
  logic [7:0]  tx_sh;
  logic [7:0]  tx_sh_d;
  logic [15:0] tx_div;
  logic [15:0] tx_div_d;
  logic        tx_q;
  logic        tx_line_d;
  logic        tx_tick;

  ser_state_t  rx_state;
  ser_state_t  rx_state_d;
  logic [15:0] rx_cnt;
  logic [15:0] rx_cnt_d;
  logic [2:0]  rx_bit;
  logic [2:0]  rx_bit_d;
  logic [7:0]  rx_sh;
  logic [7:0]  rx_sh_d;
  logic [15:0] rx_div;
  logic [15:0] rx_div_d;
  logic [1:0]  rx_sync;
  logic        rx_prev;
  logic        rx_in;
  logic        rx_s;
  logic        rx_tick;
  logic        rx_half;

  assign hit       = (io_addr_i[15:3] == BASE_ADDR[15:3]);
  assign sel       = io_addr_i[2:1];
  assign wr_data   = io_wr_i && hit && (sel == 2'd0);
  assign wr_stat   = io_wr_i && hit && (sel == 2'd1);
  assign wr_div    = io_wr_i && hit && (sel == 2'd2);
  assign wr_ctrl   = io_wr_i && hit && (sel == 2'd3);
  assign rd_data   = io_rd_i && hit && (sel == 2'd0);
  assign unused_ok = io_addr_i[0];

  assign div_eff  = (div_q < 16'd4) ? 16'd4 : div_q;
  assign tx_empty = tx_fempty && (tx_state == S_IDLE);
  assign rx_valid = !rx_fempty;
  assign irq_o    = rx_valid || (tx_empty && ctrl_q[0]);
  assign uart_tx_o = tx_q;

  assign tx_ovf_set = wr_data && !tx_acc;
  assign rx_ovf_set = rx_push && !rx_acc;

  j1_uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk    (sys_clk_i),
    .rst_n  (sys_rst_n_i),
    .push   (wr_data),
    .din    (io_data_i[7:0]),
    .pop    (tx_pop),
    .dout   (tx_head),
    .empty  (tx_fempty),
    .full   (tx_full),
    .accept (tx_acc)
  );

  j1_uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk    (sys_clk_i),
    .rst_n  (sys_rst_n_i),
    .push   (rx_push),
    .din    (rx_sh_d),
    .pop    (rd_data),
    .dout   (rx_head),
    .empty  (rx_fempty),
    .full   (rx_full),
    .accept (rx_acc)
  );

  // combinational register read mux, zero when not selected
  always_comb begin
    io_data_o = 16'h0000;
    if (hit) begin
      unique case (1'b1)
        sel == 2'd0: io_data_o = {7'b0, rx_valid, rx_head};
        sel == 2'd1: io_data_o = {10'b0, tx_ovf_q, rx_ferr_q,
                                  rx_ovf_q, rx_valid,
                                  tx_empty, tx_full};
        sel == 2'd2: io_data_o = div_q;
        sel == 2'd3: io_data_o = {14'b0, ctrl_q};
      endcase
    end
  end

  // control registers and sticky flags, set beats clear
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      div_q     <= BAUD_DIV;
      ctrl_q    <= 2'b00;
      rx_ovf_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      tx_ovf_q  <= 1'b0;
    end else begin
      if (wr_div)  div_q  <= io_data_i;
      if (wr_ctrl) ctrl_q <= io_data_i[1:0];
      rx_ovf_q  <= rx_ovf_set ||
                   (rx_ovf_q && !(wr_stat && io_data_i[3]));
      rx_ferr_q <= rx_ferr_set ||
                   (rx_ferr_q && !(wr_stat && io_data_i[4]));
      tx_ovf_q  <= tx_ovf_set ||
                   (tx_ovf_q && !(wr_stat && io_data_i[5]));
    end
  end

  assign tx_tick = (tx_cnt == tx_div - 16'd1);

  // transmitter next state; frames chain directly from STOP
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + 16'd1;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    tx_div_d   = tx_div;
    tx_pop     = 1'b0;
    tx_line_d  = 1'b1;
    unique case (tx_state)
      S_IDLE: begin
        tx_cnt_d = 16'd0;
        if (!tx_fempty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
          tx_div_d   = div_eff;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_tick) begin
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_tick) begin
          tx_cnt_d = 16'd0;
          tx_sh_d  = {1'b0, tx_sh[7:1]};
          tx_bit_d = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_tick) begin
          tx_cnt_d = 16'd0;
          if (!tx_fempty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_div_d   = div_eff;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end
      end
    endcase
    unique case (tx_state_d)
      S_IDLE:  tx_line_d = 1'b1;
      S_START: tx_line_d = 1'b0;
      S_DATA:  tx_line_d = tx_sh_d[0];
      S_STOP:  tx_line_d = 1'b1;
    endcase
  end

  // transmitter state and registered line
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'h00;
      tx_div   <= 16'd4;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      tx_div   <= tx_div_d;
      tx_q     <= tx_line_d;
    end
  end

  assign rx_in = ctrl_q[1] ? tx_q : uart_rx_i;
  assign rx_s  = rx_sync[1];

  // two-flop synchronizer plus edge history
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx_in};
      rx_prev <= rx_s;
    end
  end

  assign rx_tick = (rx_cnt == rx_div - 16'd1);
  assign rx_half = (rx_cnt == {1'b0, rx_div[15:1]} - 16'd1);

  // receiver next state: mid-bit sampling, glitch reject
  always_comb begin
    rx_state_d  = rx_state;
    rx_cnt_d    = rx_cnt + 16'd1;
    rx_bit_d    = rx_bit;
    rx_sh_d     = rx_sh;
    rx_div_d    = rx_div;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    unique case (rx_state)
      S_IDLE: begin
        rx_cnt_d = 16'd0;
        if (rx_prev && !rx_s) begin
          rx_div_d   = div_eff;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_half) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_cnt_d = 16'd0;
          rx_sh_d  = {rx_s, rx_sh[7:1]};
          rx_bit_d = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_tick) begin
          rx_cnt_d    = 16'd0;
          rx_push     = rx_s;
          rx_ferr_set = !rx_s;
          rx_state_d  = S_IDLE;
        end
      end
    endcase
  end

  // receiver state registers
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rx_state <= S_IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'h00;
      rx_div   <= 16'd4;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
      rx_div   <= rx_div_d;
    end
  end

endmodule

// File: tb/tb_j1_uart.sv
// tb_j1_uart: directed bench for j1_uart with a
// queue-based model of the serial line and register file.

module tb_j1_uart;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        rx = 1'b1;
  logic        tx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  j1_uart dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .io_rd_i     (io_rd),
    .io_wr_i     (io_wr),
    .io_addr_i   (addr),
    .io_data_i   (wdata),
    .io_data_o   (rdata),
    .uart_rx_i   (rx),
    .uart_tx_o   (tx),
    .irq_o       (irq)
  );

  // model state
  logic        txq[$];
  logic [7:0]  rxq[$];
  logic [15:0] m_div;
  logic [1:0]  m_ctrl;
  logic        m_rx_ovf;
  logic        m_rx_ferr;
  logic        m_tx_ovf;
  bit          tx_track;
  bit          stall;
  bit          m_shift;
  int          m_txcnt;
  logic        e_tx;
  logic [15:0] d;

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    txq.delete();
    rxq.delete();
    m_div = 16'd434;
    m_ctrl = 2'b00;
    m_rx_ovf = 1'b0;
    m_rx_ferr = 1'b0;
    m_tx_ovf = 1'b0;
    m_shift = 1'b0;
    m_txcnt = 0;
  endfunction

  function automatic int eff_div();
    return (m_div < 16'd4) ? 4 : int'(m_div);
  endfunction

  function automatic logic m_tx_empty();
    return !stall && (txq.size() == 0);
  endfunction

  function automatic logic [15:0] exp_read(input logic [15:0] a);
    logic        rv;
    logic [15:0] r;
    rv = (rxq.size() != 0);
    r = 16'h0000;
    if (a[15:3] == 13'h0800) begin
      case (a[2:1])
        2'd0: r = {7'b0, rv, rv ? rxq[0] : 8'h00};
        2'd1: r = {10'b0, m_tx_ovf, m_rx_ferr, m_rx_ovf, rv,
                   m_tx_empty(), stall && (m_txcnt == 16)};
        2'd2: r = m_div;
        default: r = {14'b0, m_ctrl};
      endcase
    end
    return r;
  endfunction

  // one idle clock if the line is quiet, then start/8 data/stop
  function automatic void queue_frame(input logic [7:0] b);
    int n;
    logic [9:0] f;
    n = eff_div();
    f = {1'b1, b, 1'b0};
    if (txq.size() == 0) txq.push_back(1'b1);
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < n; k++) txq.push_back(f[i]);
  endfunction

  // compare process and bus-observing model update
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_track) begin
        e_tx = (txq.size() != 0) ? txq.pop_front() : 1'b1;
        check("tx_line", {15'b0, tx}, {15'b0, e_tx});
      end
      if (io_rd) begin
        check("rd_data", rdata, exp_read(addr));
        if (addr[15:3] == 13'h0800) begin
          check("irq", {15'b0, irq},
                {15'b0, (rxq.size() != 0) ||
                        (m_tx_empty() && m_ctrl[0])});
          if (addr[2:1] == 2'd0 && rxq.size() != 0) rxq.delete(0);
        end
      end
      if (io_wr && addr[15:3] == 13'h0800) begin
        case (addr[2:1])
          2'd0: begin
            if (stall) begin
              if (!m_shift) m_shift = 1'b1;
              else if (m_txcnt < 16) m_txcnt++;
              else m_tx_ovf = 1'b1;
            end else begin
              queue_frame(wdata[7:0]);
            end
          end
          2'd1: begin
            if (wdata[3]) m_rx_ovf = 1'b0;
            if (wdata[4]) m_rx_ferr = 1'b0;
            if (wdata[5]) m_tx_ovf = 1'b0;
          end
          2'd2: m_div = wdata;
          default: m_ctrl = wdata[1:0];
        endcase
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] v);
    @(posedge clk);
    #1;
    io_wr = 1'b1;
    addr = a;
    wdata = v;
    @(posedge clk);
    #1;
    io_wr = 1'b0;
    addr = 16'h0000;
    wdata = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    @(posedge clk);
    #1;
    io_rd = 1'b1;
    addr = a;
    #2;
    v = rdata;
    @(posedge clk);
    #1;
    io_rd = 1'b0;
    addr = 16'h0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // drive one serial frame, then fold its outcome into the model
  task automatic inject(input logic [7:0] b, input logic stopb,
                        input int n);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (n) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    if (!stopb) m_rx_ferr = 1'b1;
    else if (rxq.size() < 16) rxq.push_back(b);
    else m_rx_ovf = 1'b1;
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    m_reset();
    tx_track = 1'b1;
    stall = 1'b0;
    #12;
    check("rst_tx", {15'b0, tx}, 16'h0001);
    check("rst_irq", {15'b0, irq}, 16'h0000);
    #10;
    rst_n = 1'b1;
    idle(3);

    rd(16'h4002, d); check("rst_status", d, 16'h0002);
    rd(16'h4004, d); check("rst_div", d, 16'h01B2);
    rd(16'h4006, d); check("rst_ctrl", d, 16'h0000);
    rd(16'h4000, d); check("rst_data", d, 16'h0000);

    wr(16'h4004, 16'd4);
    wr(16'h4000, 16'h0055);
    @(posedge clk);
    #2;
    check("tx_start_bit", {15'b0, tx}, 16'h0000);
    repeat (4) @(posedge clk);
    #2;
    check("tx_bit0", {15'b0, tx}, 16'h0001);
    idle(50);
    rd(16'h4002, d); check("tx_done_status", d, 16'h0002);

    wr(16'h4004, 16'd1);
    rd(16'h4004, d);
    wr(16'h4000, 16'h00C6);
    idle(50);

    wr(16'h4004, 16'd8);
    wr(16'h4006, 16'h0002);
    wr(16'h4000, 16'h00A3);
    idle(110);
    rxq.push_back(8'hA3);
    rd(16'h4000, d); check("loop_data", d, 16'h01A3);
    rd(16'h4000, d); check("loop_empty", d, 16'h0000);
    wr(16'h4006, 16'h0000);

    wr(16'h4006, 16'h0001);
    rd(16'h4002, d);
    check("irq_tx_en", {15'b0, irq}, 16'h0001);
    wr(16'h4006, 16'h0000);

    wr(16'h0100, 16'hFFFF);
    wr(16'h0102, 16'hFFFF);
    wr(16'h0104, 16'hFFFF);
    wr(16'h0106, 16'hFFFF);
    idle(10);
    rd(16'h4002, d);
    rd(16'h4004, d);
    rd(16'h4006, d);
    rd(16'h0100, d); check("undecoded_rd", d, 16'h0000);

    for (int i = 0; i < 17; i++)
      inject(8'((i * 37 + 5) & 255), 1'b1, 8);
    idle(5);
    rd(16'h4002, d); check("rx_ovf_status", d, 16'h000E);
    rd(16'h4000, d); check("rx_first", d, 16'h0105);
    for (int i = 1; i < 16; i++) rd(16'h4000, d);
    rd(16'h4002, d); check("rx_drained", d, 16'h000A);
    wr(16'h4002, 16'h0008);
    rd(16'h4002, d);

    inject(8'h5A, 1'b0, 8);
    @(posedge clk);
    #1;
    rx = 1'b0;
    @(posedge clk);
    #1;
    rx = 1'b1;
    idle(40);
    rd(16'h4002, d); check("ferr_status", d, 16'h0012);
    rd(16'h4000, d); check("ferr_nodata", d, 16'h0000);
    wr(16'h4002, 16'h0018);
    rd(16'h4002, d);

    wr(16'h4004, 16'd434);
    tx_track = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 18; i++) wr(16'h4000, 16'(i));
    rd(16'h4002, d); check("tx_ovf_status", d, 16'h0021);
    wr(16'h4002, 16'h0020);
    rd(16'h4002, d); check("tx_ovf_clear", d, 16'h0001);

    @(posedge clk);
    #3;
    check("tx_mid_frame", {15'b0, tx}, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("tx_async_rst", {15'b0, tx}, 16'h0001);
    check("irq_async_rst", {15'b0, irq}, 16'h0000);
    m_reset();
    stall = 1'b0;
    tx_track = 1'b1;
    #20;
    rst_n = 1'b1;
    idle(30);
    rd(16'h4002, d); check("post_rst_status", d, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
